// File: rtl/mirq_ctrl_pkg.sv
// Shared definitions for the machine-mode interrupt front end:
// CSR numbers, bit positions, cause codes, CSR op encodings and FSM states.
package mirq_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int BIT_MSI      = 3;
    localparam int BIT_MTI      = 7;
    localparam int BIT_MEI      = 11;
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] IRQ_MASK     = 32'h0000_0888;
    localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;

    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } trap_state_e;

    function automatic logic [31:0] csr_modify(input csr_op_e op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] wdata);
        case (op)
            CSR_OP_WRITE: csr_modify = wdata;
            CSR_OP_SET:   csr_modify = old_val | wdata;
            CSR_OP_CLEAR: csr_modify = old_val & ~wdata;
            default:      csr_modify = old_val;
        endcase
    endfunction

endpackage

// File: rtl/mirq_ctrl_irq_prio_enc.sv
// Fixed-priority interrupt encoder: MEI > MSI > MTI.
// Produces the mcause value for the highest-priority pending interrupt.
module irq_prio_enc
    import mirq_ctrl_pkg::*;
(
    input  logic [11:0] pend,
    output logic        any,
    output logic [31:0] cause
);

    localparam logic [11:0] PEND_MASK = IRQ_MASK[11:0];

    always_comb begin
        any   = |(pend & PEND_MASK);
        cause = '0;
        if (pend[BIT_MEI])
            cause = CAUSE_MEI;
        else if (pend[BIT_MSI])
            cause = CAUSE_MSI;
        else if (pend[BIT_MTI])
            cause = CAUSE_MTI;
    end

endmodule

// File: rtl/mirq_ctrl.sv
// Machine-mode interrupt front end: mip/mie/mstatus registers, CSR port,
// and the trap request FSM that hands interrupts to the core at boundaries.
//
//  state   | meaning
//  IDLE    | no request outstanding; watch for enabled pending IRQ at a boundary
//  REQ     | trap_req held with frozen cause until the core acks
module mirq_ctrl
    import mirq_ctrl_pkg::*;
#(
    parameter bit RESET_MIE = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        msip_i,
    input  logic        mtip_i,
    input  logic        meip_i,
    input  logic        csr_valid,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    output logic        csr_hit,
    output logic        csr_ready,
    output logic [31:0] csr_rdata,
    input  logic        instr_boundary,
    output logic        trap_req,
    output logic [31:0] trap_cause,
    input  logic        trap_ack,
    input  logic        mret
);

    localparam logic [31:0] MSTATUS_RST = 32'(RESET_MIE) << MSTATUS_MIE;

    trap_state_e state_q, state_nxt;
    logic        msip_q, mtip_q, meip_q;
    logic [31:0] mip_val, mie_q, mstatus_q, mstatus_nxt;
    logic [31:0] csr_old, csr_new, cause_q, enc_cause;
    logic [11:0] pend;
    logic        pend_any, csr_accept, csr_wr, take_ack, csr_ready_q;
    logic [31:0] csr_rdata_q;

    always_comb begin
        mip_val          = '0;
        mip_val[BIT_MSI] = msip_q;
        mip_val[BIT_MTI] = mtip_q;
        mip_val[BIT_MEI] = meip_q;
    end

    assign pend = mip_val[11:0] & mie_q[11:0];

    irq_prio_enc u_prio (
        .pend  (pend),
        .any   (pend_any),
        .cause (enc_cause)
    );

    assign csr_hit    = csr_valid && (csr_addr == CSR_MSTATUS ||
                                      csr_addr == CSR_MIE ||
                                      csr_addr == CSR_MIP);
    // A ready cycle blocks re-acceptance of the still-held strobe.
    assign csr_accept = csr_hit && !csr_ready_q;
    assign csr_wr     = csr_accept && (csr_op != CSR_OP_READ);

    always_comb begin
        case (csr_addr)
            CSR_MSTATUS: csr_old = mstatus_q;
            CSR_MIE:     csr_old = mie_q;
            CSR_MIP:     csr_old = mip_val;
            default:     csr_old = '0;
        endcase
    end

    assign csr_new = csr_modify(csr_op_e'(csr_op), csr_old, csr_wdata);

    always_comb begin
        state_nxt = state_q;
        take_ack  = 1'b0;
        case (state_q)
            ST_IDLE: if (instr_boundary && mstatus_q[MSTATUS_MIE] && pend_any)
                         state_nxt = ST_REQ;
            ST_REQ:  if (trap_ack) begin
                         take_ack  = 1'b1;
                         state_nxt = ST_IDLE;
                     end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Later assignments win: trap entry over mret over the CSR write.
    always_comb begin
        mstatus_nxt = mstatus_q;
        if (csr_wr && csr_addr == CSR_MSTATUS)
            mstatus_nxt = csr_new & MSTATUS_MASK;
        if (mret) begin
            mstatus_nxt[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
            mstatus_nxt[MSTATUS_MPIE] = 1'b1;
        end
        if (take_ack) begin
            mstatus_nxt[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
            mstatus_nxt[MSTATUS_MIE]  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cause_q     <= '0;
            msip_q      <= 1'b0;
            mtip_q      <= 1'b0;
            meip_q      <= 1'b0;
            mie_q       <= '0;
            mstatus_q   <= MSTATUS_RST;
            csr_ready_q <= 1'b0;
            csr_rdata_q <= '0;
        end else begin
            state_q     <= state_nxt;
            msip_q      <= msip_i;
            mtip_q      <= mtip_i;
            meip_q      <= meip_i;
            mstatus_q   <= mstatus_nxt;
            csr_ready_q <= csr_accept;
            if (state_q == ST_IDLE && state_nxt == ST_REQ)
                cause_q <= enc_cause;
            if (csr_accept)
                csr_rdata_q <= csr_old;
            if (csr_wr && csr_addr == CSR_MIE)
                mie_q <= csr_new & IRQ_MASK;
        end
    end

    assign trap_req   = (state_q == ST_REQ);
    assign trap_cause = cause_q;
    assign csr_ready  = csr_ready_q;
    assign csr_rdata  = csr_rdata_q;

endmodule

// File: tb/tb_mirq_ctrl.sv
// Self-checking bench for mirq_ctrl: expected CSR read data and trap causes
// are queued when stimulus is issued and compared when the DUT responds.
module tb_mirq_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        msip_i = 1'b0, mtip_i = 1'b0, meip_i = 1'b0;
    logic        csr_valid = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [1:0]  csr_op = '0;
    logic [31:0] csr_wdata = '0;
    logic        csr_hit, csr_ready;
    logic [31:0] csr_rdata;
    logic        instr_boundary = 1'b0;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic        trap_ack = 1'b0;
    logic        mret = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] csr_q[$];
    logic [31:0] trap_q[$];

    mirq_ctrl #(.RESET_MIE(1'b0)) dut (
        .clk(clk), .resetn(resetn),
        .msip_i(msip_i), .mtip_i(mtip_i), .meip_i(meip_i),
        .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_hit(csr_hit), .csr_ready(csr_ready),
        .csr_rdata(csr_rdata), .instr_boundary(instr_boundary),
        .trap_req(trap_req), .trap_cause(trap_cause),
        .trap_ack(trap_ack), .mret(mret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge; returns at a negedge with the strobe released.
    task automatic csr_acc(input logic [11:0] addr, input logic [1:0] op,
                           input logic [31:0] wd, input logic [31:0] exp,
                           input bit with_ack);
        int cyc;
        logic [31:0] e;
        csr_q.push_back(exp);
        csr_addr  = addr;
        csr_op    = op;
        csr_wdata = wd;
        csr_valid = 1'b1;
        if (with_ack) trap_ack = 1'b1;
        #1 chk("csr_hit", {31'b0, csr_hit}, 32'd1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            trap_ack = 1'b0;
        end while (!csr_ready && cyc < 8);
        e = csr_q.pop_front();
        if (!csr_ready)
            chk("csr_ready_timeout", 32'd0, 32'd1);
        else begin
            chk("csr_latency", cyc, 32'd1);
            chk("csr_rdata", csr_rdata, e);
        end
        csr_valid = 1'b0;
        @(negedge clk);
        chk("csr_ready_single", {31'b0, csr_ready}, 32'd0);
    endtask

    task automatic wait_trap(input logic [31:0] exp);
        int cyc;
        logic [31:0] e;
        trap_q.push_back(exp);
        cyc = 0;
        while (!trap_req && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        e = trap_q.pop_front();
        if (!trap_req)
            chk("trap_timeout", 32'd0, 32'd1);
        else
            chk("trap_cause", trap_cause, e);
    endtask

    task automatic do_ack();
        trap_ack = 1'b1;
        @(negedge clk);
        trap_ack = 1'b0;
        chk("trap_req_after_ack", {31'b0, trap_req}, 32'd0);
    endtask

    task automatic do_mret();
        mret = 1'b1;
        @(negedge clk);
        mret = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_trap_req", {31'b0, trap_req}, 32'd0);
        chk("rst_trap_cause", trap_cause, 32'd0);
        chk("rst_csr_ready", {31'b0, csr_ready}, 32'd0);
        chk("rst_csr_rdata", csr_rdata, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        csr_acc(12'h300, 2'b00, 32'h0, 32'h0, 1'b0);
        csr_acc(12'h304, 2'b00, 32'h0, 32'h0, 1'b0);
        csr_acc(12'h344, 2'b00, 32'h0, 32'h0, 1'b0);

        // Unmapped CSR: no hit, never ready.
        csr_addr = 12'h305; csr_op = 2'b00; csr_valid = 1'b1;
        #1 chk("miss_hit", {31'b0, csr_hit}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("miss_ready", {31'b0, csr_ready}, 32'd0);
        end
        csr_valid = 1'b0;
        @(negedge clk);

        // Timer interrupt round trip.
        csr_acc(12'h304, 2'b01, 32'h880, 32'h0, 1'b0);
        csr_acc(12'h300, 2'b01, 32'h8, 32'h0, 1'b0);
        mtip_i = 1'b1; instr_boundary = 1'b1;
        wait_trap(32'h8000_0007);
        mtip_i = 1'b0; instr_boundary = 1'b0;
        do_ack();
        csr_acc(12'h300, 2'b00, 32'h0, 32'h80, 1'b0);
        do_mret();
        csr_acc(12'h300, 2'b00, 32'h0, 32'h88, 1'b0);

        // Priority: MEI first, then MSI once MEI drops.
        csr_acc(12'h304, 2'b01, 32'h888, 32'h880, 1'b0);
        msip_i = 1'b1; mtip_i = 1'b1; meip_i = 1'b1; instr_boundary = 1'b1;
        wait_trap(32'h8000_000B);
        instr_boundary = 1'b0;
        csr_acc(12'h344, 2'b01, 32'h0, 32'h888, 1'b0);
        csr_acc(12'h344, 2'b00, 32'h0, 32'h888, 1'b0);
        do_ack();
        meip_i = 1'b0;
        do_mret();
        instr_boundary = 1'b1;
        wait_trap(32'h8000_0003);
        instr_boundary = 1'b0;

        // No retraction while REQ.
        msip_i = 1'b0; mtip_i = 1'b0;
        csr_acc(12'h304, 2'b11, 32'hFFF, 32'h888, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_req", {31'b0, trap_req}, 32'd1);
            chk("hold_cause", trap_cause, 32'h8000_0003);
        end

        // Ack beats a concurrent CSR set of MIE.
        csr_acc(12'h300, 2'b10, 32'h8, 32'h88, 1'b1);
        chk("ack_vs_csr_req", {31'b0, trap_req}, 32'd0);
        csr_acc(12'h300, 2'b00, 32'h0, 32'h80, 1'b0);

        // Ack in IDLE has no effect on mstatus.
        trap_ack = 1'b1;
        @(negedge clk);
        trap_ack = 1'b0;
        csr_acc(12'h300, 2'b00, 32'h0, 32'h80, 1'b0);

        // Reset while a request is outstanding.
        csr_acc(12'h300, 2'b01, 32'h8, 32'h80, 1'b0);
        csr_acc(12'h304, 2'b01, 32'h80, 32'h0, 1'b0);
        mtip_i = 1'b1; instr_boundary = 1'b1;
        wait_trap(32'h8000_0007);
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_mid_req", {31'b0, trap_req}, 32'd0);
        chk("rst_mid_cause", trap_cause, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // MIE=0 after reset: pending stays visible, no request.
        csr_acc(12'h304, 2'b01, 32'h80, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mie0_no_req", {31'b0, trap_req}, 32'd0);
        end
        csr_acc(12'h344, 2'b00, 32'h0, 32'h80, 1'b0);
        csr_acc(12'h300, 2'b00, 32'h0, 32'h0, 1'b0);
        instr_boundary = 1'b0; mtip_i = 1'b0;

        chk("scoreboard_empty", csr_q.size() + trap_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
